// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared constants, FSM state encoding and helper functions
//               for the UART receive path (and the TX path that will reuse
//               the FIFO).
// Contents    : PAR_NONE/PAR_ODD/PAR_EVEN parity-mode codes,
//               rx_state_e receiver FSM states,
//               f_parity()   expected parity bit for a character,
//               f_majority() 2-of-3 vote used for bit sampling.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Parity-mode codes; these match the numeric C_PARITY parameter values.
  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_ODD  = 2'd1;
  localparam logic [1:0] PAR_EVEN = 2'd2;

  // Widest character the receiver supports.
  localparam int MAX_DATA_BITS = 9;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_PUSH      = 3'd5,
    ST_WAIT_IDLE = 3'd6
  } rx_state_e;

  // Expected parity bit. Callers zero-extend narrower characters, which does
  // not change the XOR reduction.
  function automatic logic f_parity(input logic [MAX_DATA_BITS-1:0] data,
                                    input logic [1:0]               mode);
    logic p;
    p = ^data;
    return (mode == PAR_ODD) ? ~p : p;
  endfunction

  function automatic logic f_majority(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_sync_fifo
// Description : Single-clock first-word-fall-through FIFO. The head entry is
//               presented combinationally whenever the FIFO is non-empty.
//               A push into a full FIFO is accepted only when a pop happens
//               in the same cycle; a pop from an empty FIFO is ignored.
// Ports       : clk_i    clock
//               rst_i    synchronous active-high reset (clears pointers)
//               push_i   write request, wdata_i written when accepted
//               pop_i    read request, head removed when non-empty
//               rdata_o  head entry (zero while empty)
//               full_o   occupancy == depth
//               empty_o  occupancy == 0
//               count_o  occupancy, 0..depth
// Revision    : 1.0 - initial release
// ============================================================================
module uart_sync_fifo #(
  parameter int WIDTH = 10,
  parameter int AW    = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  localparam int DEPTH = 2 ** AW;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      wr_ptr_d;
  logic [AW:0]      rd_ptr_q;
  logic [AW:0]      rd_ptr_d;
  logic             pop_ok;
  logic             push_ok;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count_o = wr_ptr_q - rd_ptr_q;

  assign pop_ok  = pop_i && !empty_o;
  // A simultaneous pop frees the slot the push needs.
  assign push_ok = push_i && (!full_o || pop_ok);

  // Gated so the head reads as zero after reset and while empty.
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: it is only observable through a valid pointer.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : Parametrised UART receiver with 3-sample majority voting,
//               optional parity, 1 or 2 stop bits, per-character error flags,
//               break detection and a receive FIFO with sticky overflow.
// Ports       : CLK_100M  system clock
//               IO_RESET  synchronous active-high reset
//               UART_RXD  asynchronous serial input, idle high
//               RX_DATA   FIFO head character, LSB received first
//               RX_PERR   parity error flag of the head entry
//               RX_FERR   framing error flag of the head entry
//               RX_VLD    FIFO non-empty
//               RX_RDY    consumer pop (effective when RX_VLD)
//               RX_OVF    sticky overflow flag
//               OVF_CLR   clears RX_OVF (a same-cycle overflow wins)
//               RX_BREAK  one-cycle pulse on break detect
//               FIFO_CNT  FIFO occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned C_BIT_CNT   = 12'h364,
  parameter int          C_DATA_BITS = 8,
  parameter int          C_PARITY    = 0,
  parameter int          C_STOP_BITS = 1,
  parameter int          C_FIFO_AW   = 4
) (
  input  logic                   CLK_100M,
  input  logic                   IO_RESET,
  input  logic                   UART_RXD,
  output logic [C_DATA_BITS-1:0] RX_DATA,
  output logic                   RX_PERR,
  output logic                   RX_FERR,
  output logic                   RX_VLD,
  input  logic                   RX_RDY,
  output logic                   RX_OVF,
  input  logic                   OVF_CLR,
  output logic                   RX_BREAK,
  output logic [C_FIFO_AW:0]     FIFO_CNT
);

  localparam int         C_ENTRY_W   = C_DATA_BITS + 2;
  localparam logic [1:0] C_PAR_MODE  = 2'(C_PARITY);
  localparam bit         C_HAS_PAR   = (C_PAR_MODE != PAR_NONE);
  localparam logic [11:0] C_HALF     = 12'(C_BIT_CNT / 2);
  localparam logic [11:0] C_HALF_M1  = C_HALF - 12'd1;
  localparam logic [11:0] C_HALF_P1  = C_HALF + 12'd1;
  localparam logic [11:0] C_LAST     = 12'(C_BIT_CNT - 1);
  localparam logic [3:0]  C_LAST_BIT = 4'(C_DATA_BITS - 1);
  localparam logic        C_LAST_STP = 1'(C_STOP_BITS - 1);

  // --------------------------------------------------------------------------
  // Input synchronizer plus one edge-detect stage. Everything presets to the
  // idle level so reset never manufactures a start edge.
  // --------------------------------------------------------------------------
  logic sync1_q;
  logic sync2_q;
  logic edge_q;
  logic line;
  logic start_edge;

  always_ff @(posedge CLK_100M) begin
    if (IO_RESET) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      edge_q  <= 1'b1;
    end else begin
      sync1_q <= UART_RXD;
      sync2_q <= sync1_q;
      edge_q  <= sync2_q;
    end
  end

  assign line       = sync2_q;
  assign start_edge = edge_q & ~sync2_q;

  // --------------------------------------------------------------------------
  // Receiver FSM with bit timer and sample registers
  // --------------------------------------------------------------------------
  rx_state_e              state_q, state_d;
  logic [11:0]            tmr_q, tmr_d;
  logic [1:0]             samp_q, samp_d;
  logic [3:0]             bit_q, bit_d;
  logic                   stop_q, stop_d;
  logic [C_DATA_BITS-1:0] data_q, data_d;
  logic                   perr_q, perr_d;
  logic                   ferr_q, ferr_d;
  logic                   par_q, par_d;

  logic                   at_h1;
  logic                   at_end;
  logic                   maj;
  logic                   is_break;
  logic                   push;
  logic [MAX_DATA_BITS-1:0] data_ext;

  assign at_h1    = (tmr_q == C_HALF_P1);
  assign at_end   = (tmr_q == C_LAST);
  // Third vote is the live sample at H+1, so the result is usable this cycle.
  assign maj      = f_majority(samp_q[0], samp_q[1], line);
  assign data_ext = MAX_DATA_BITS'(data_q);
  // A received parity bit of 1 means the line was not held low throughout.
  assign is_break = (data_q == '0) && ferr_q && (!C_HAS_PAR || !par_q);

  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q + 12'd1;
    samp_d   = samp_q;
    bit_d    = bit_q;
    stop_d   = stop_q;
    data_d   = data_q;
    perr_d   = perr_q;
    ferr_d   = ferr_q;
    par_d    = par_q;
    push     = 1'b0;
    RX_BREAK = 1'b0;

    if (tmr_q == C_HALF_M1) samp_d[0] = line;
    if (tmr_q == C_HALF)    samp_d[1] = line;

    case (state_q)
      ST_IDLE: begin
        tmr_d = '0;
        if (start_edge) begin
          state_d = ST_START;
          bit_d   = '0;
          stop_d  = 1'b0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
          par_d   = 1'b0;
        end
      end

      ST_START: begin
        if (at_h1 && maj) begin
          // Line back high mid-bit: glitch, not a start bit.
          state_d = ST_IDLE;
          tmr_d   = '0;
        end else if (at_end) begin
          state_d = ST_DATA;
          tmr_d   = '0;
        end
      end

      ST_DATA: begin
        if (at_h1) data_d = {maj, data_q[C_DATA_BITS-1:1]};
        if (at_end) begin
          tmr_d = '0;
          if (bit_q == C_LAST_BIT) begin
            state_d = C_HAS_PAR ? ST_PARITY : ST_STOP;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end

      ST_PARITY: begin
        if (at_h1) begin
          par_d  = maj;
          perr_d = (maj != f_parity(data_ext, C_PAR_MODE));
        end
        if (at_end) begin
          state_d = ST_STOP;
          tmr_d   = '0;
        end
      end

      ST_STOP: begin
        if (at_h1) begin
          if (!maj) ferr_d = 1'b1;
          // The last stop bit is decided at its sample point so that a
          // back-to-back start edge is not missed.
          if (stop_q == C_LAST_STP) begin
            state_d = ST_PUSH;
            tmr_d   = '0;
          end
        end else if (at_end) begin
          tmr_d  = '0;
          stop_d = 1'b1;
        end
      end

      ST_PUSH: begin
        tmr_d = '0;
        if (is_break) RX_BREAK = 1'b1;
        else          push     = 1'b1;
        state_d = ferr_q ? ST_WAIT_IDLE : ST_IDLE;
      end

      ST_WAIT_IDLE: begin
        // Timer doubles as a count of consecutive high cycles.
        if (!line) begin
          tmr_d = '0;
        end else if (at_end) begin
          state_d = ST_IDLE;
          tmr_d   = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        tmr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK_100M) begin
    if (IO_RESET) begin
      state_q <= ST_IDLE;
      tmr_q   <= '0;
      samp_q  <= 2'b11;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      data_q  <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      samp_q  <= samp_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      data_q  <= data_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      par_q   <= par_d;
    end
  end

  // --------------------------------------------------------------------------
  // Receive FIFO and overflow tracking
  // --------------------------------------------------------------------------
  logic [C_ENTRY_W-1:0] fifo_rdata;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 pop;
  logic                 drop;
  logic                 ovf_q;

  assign pop  = RX_RDY && !fifo_empty;
  assign drop = push && fifo_full && !pop;

  uart_sync_fifo #(
    .WIDTH (C_ENTRY_W),
    .AW    (C_FIFO_AW)
  ) u_fifo (
    .clk_i   (CLK_100M),
    .rst_i   (IO_RESET),
    .push_i  (push),
    .wdata_i ({perr_q, ferr_q, data_q}),
    .pop_i   (RX_RDY),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (FIFO_CNT)
  );

  always_ff @(posedge CLK_100M) begin
    if (IO_RESET)     ovf_q <= 1'b0;
    else if (drop)    ovf_q <= 1'b1;
    else if (OVF_CLR) ovf_q <= 1'b0;
  end

  assign RX_VLD  = !fifo_empty;
  assign RX_OVF  = ovf_q;
  assign RX_PERR = fifo_rdata[C_ENTRY_W-1];
  assign RX_FERR = fifo_rdata[C_ENTRY_W-2];
  assign RX_DATA = fifo_rdata[C_DATA_BITS-1:0];

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_fifo
// Description : Self-checking bench for uart_rx_fifo. Instance A is 8N1 with
//               a 16-deep FIFO, instance B is 7 data bits, even parity, two
//               stop bits, 4-deep FIFO. Frames are built bit by bit from the
//               character, and the expected FIFO entries, break pulses and
//               overflow behaviour are derived from the frame contents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

  localparam int BIT   = 32;
  localparam int DEPTH = 16;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       rxd_a = 1'b1;
  logic       rxd_b = 1'b1;
  logic       rdy_a = 1'b0;
  logic       rdy_b = 1'b1;
  logic       clr_a = 1'b0;
  logic       clr_b = 1'b0;

  logic [7:0] data_a;
  logic       perr_a, ferr_a, vld_a, ovf_a, brk_a;
  logic [4:0] cnt_a;
  logic [6:0] data_b;
  logic       perr_b, ferr_b, vld_b, ovf_b, brk_b;
  logic [2:0] cnt_b;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .C_BIT_CNT(BIT), .C_DATA_BITS(8), .C_PARITY(0), .C_STOP_BITS(1), .C_FIFO_AW(4)
  ) dut_a (
    .CLK_100M(clk), .IO_RESET(rst), .UART_RXD(rxd_a),
    .RX_DATA(data_a), .RX_PERR(perr_a), .RX_FERR(ferr_a), .RX_VLD(vld_a),
    .RX_RDY(rdy_a), .RX_OVF(ovf_a), .OVF_CLR(clr_a), .RX_BREAK(brk_a),
    .FIFO_CNT(cnt_a)
  );

  uart_rx_fifo #(
    .C_BIT_CNT(BIT), .C_DATA_BITS(7), .C_PARITY(2), .C_STOP_BITS(2), .C_FIFO_AW(2)
  ) dut_b (
    .CLK_100M(clk), .IO_RESET(rst), .UART_RXD(rxd_b),
    .RX_DATA(data_b), .RX_PERR(perr_b), .RX_FERR(ferr_b), .RX_VLD(vld_b),
    .RX_RDY(rdy_b), .RX_OVF(ovf_b), .OVF_CLR(clr_b), .RX_BREAK(brk_b),
    .FIFO_CNT(cnt_b)
  );

  // --------------------------------------------------------------------------
  // Checking and reference model state
  // --------------------------------------------------------------------------
  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected entries {perr, ferr, data[7:0]} in arrival order.
  logic [9:0] qa[$];
  logic [9:0] qb[$];
  int exp_brk_a = 0, exp_brk_b = 0;
  int brk_cnt_a = 0, brk_cnt_b = 0;
  int n_pop_a = 0, max_cnt_a = 0;
  bit rnd_rdy = 1'b0;

  // Consumer side: compare every popped head entry with the model queue.
  always @(negedge clk) begin
    logic [10:0] e;
    if (!rst) begin
      if (brk_a) brk_cnt_a++;
      if (brk_b) brk_cnt_b++;
      if (int'(cnt_a) > max_cnt_a) max_cnt_a = int'(cnt_a);
      if (vld_a && rdy_a) begin
        // 11'h400 can never match a 10-bit entry: flags an unexpected pop.
        e = (qa.size() != 0) ? {1'b0, qa.pop_front()} : 11'h400;
        check("a_entry", {22'd0, perr_a, ferr_a, data_a}, {21'd0, e});
        n_pop_a++;
      end
      if (vld_b && rdy_b) begin
        e = (qb.size() != 0) ? {1'b0, qb.pop_front()} : 11'h400;
        check("b_entry", {22'd0, perr_b, ferr_b, 1'b0, data_b}, {21'd0, e});
      end
    end
  end

  // Random consumer back-pressure during the random phase.
  always @(posedge clk) begin
    if (rnd_rdy) begin
      #1;
      rdy_a = 1'($urandom_range(0, 1));
      rdy_b = 1'($urandom_range(0, 1));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input int port, input logic v);
    if (port == 0) rxd_a = v;
    else           rxd_b = v;
    tick(BIT);
  endtask

  // Sends one frame. Port 0: 8N1. Port 1: 7 bits, even parity (inverted when
  // bad_par), 2 stop bits. sv gives the stop-bit levels. When model is set,
  // the expected outcome is recorded before the frame goes out.
  task automatic send(input int port, input logic [7:0] d, input bit bad_par,
                      input logic [1:0] sv, input int gap, input bit model);
    logic [7:0] dm;
    logic       p, ferr, perr;
    bit         brk;
    dm   = (port == 0) ? d : {1'b0, d[6:0]};
    p    = (port == 0) ? 1'b0 : ((^d[6:0]) ^ bad_par);
    ferr = (port == 0) ? !sv[0] : !(sv[0] & sv[1]);
    perr = (port == 1) && bad_par;
    brk  = (dm == 8'd0) && ferr && (port == 0 || !p);
    if (model) begin
      if (brk) begin
        if (port == 0) exp_brk_a++;
        else           exp_brk_b++;
      end else if (port == 0) begin
        if (qa.size() < DEPTH) qa.push_back({perr, ferr, dm});
      end else begin
        qb.push_back({perr, ferr, dm});
      end
    end
    drive(port, 1'b0);
    for (int i = 0; i < ((port == 0) ? 8 : 7); i++) drive(port, dm[i]);
    if (port == 1) drive(port, p);
    drive(port, sv[0]);
    if (port == 1) drive(port, sv[1]);
    if (port == 0) rxd_a = 1'b1;
    else           rxd_b = 1'b1;
    if (gap > 0) tick(gap);
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    int p0, b0;
    logic [7:0] d;
    logic [1:0] sv;
    bit bad;

    tick(4);
    rst = 1'b0;
    @(negedge clk);
    check("reset_vld_a", vld_a, 0);
    check("reset_cnt_a", cnt_a, 0);
    check("reset_flags_a", {ovf_a, brk_a, perr_a, ferr_a}, 0);
    check("reset_data_a", data_a, 0);
    check("reset_b", {vld_b, ovf_b, brk_b, cnt_b}, 0);

    // Back-to-back 8N1 characters with an always-ready consumer.
    rdy_a = 1'b1;
    max_cnt_a = 0;
    p0 = n_pop_a;
    send(0, 8'h55, 0, 2'b11, 0, 1);
    send(0, 8'hA3, 0, 2'b11, BIT, 1);
    check("b2b_pops", n_pop_a - p0, 2);
    check("b2b_max_cnt", max_cnt_a, 1);
    check("b2b_all_seen", qa.size(), 0);

    // 7E2: correct then inverted parity on 0x41.
    send(1, 8'h41, 0, 2'b11, 4, 1);
    send(1, 8'h41, 1, 2'b11, BIT, 1);
    check("par_all_seen", qb.size(), 0);

    // Short glitch, then a valid character.
    p0 = n_pop_a;
    rxd_a = 1'b0;
    tick(10);
    rxd_a = 1'b1;
    tick(2 * BIT);
    check("glitch_no_push", n_pop_a - p0, 0);
    send(0, 8'h3C, 0, 2'b11, BIT, 1);
    check("glitch_next_ok", qa.size(), 0);

    // Framing error, then a start edge before the line has idled a full bit
    // (not modelled: it must be ignored), then a properly spaced character.
    send(0, 8'h7E, 0, 2'b10, 5, 1);
    send(0, 8'hFF, 0, 2'b11, BIT + 8, 0);
    send(0, 8'h5A, 0, 2'b11, BIT, 1);
    check("ferr_all_seen", qa.size(), 0);

    // Overflow: 17 characters into a 16-deep FIFO with no consumer.
    rdy_a = 1'b0;
    for (int i = 0; i < 17; i++) begin
      if (i == 16) begin
        @(negedge clk);
        check("ovf_before", {ovf_a, cnt_a}, {1'b0, 5'd16});
      end
      send(0, 8'($urandom), 0, 2'b11, 2, 1);
    end
    @(negedge clk);
    check("ovf_cnt", cnt_a, 16);
    check("ovf_flag", ovf_a, 1);
    @(posedge clk); #1;
    clr_a = 1'b1;
    tick(1);
    clr_a = 1'b0;
    @(negedge clk);
    check("ovf_clr", ovf_a, 0);
    rdy_a = 1'b1;
    for (int i = 0; i < 200 && vld_a; i++) tick(1);
    @(negedge clk);
    check("drain_vld", vld_a, 0);
    check("drain_cnt", cnt_a, 0);
    check("drain_all_seen", qa.size(), 0);

    // Break: line low for 12 bit times.
    @(posedge clk); #1;
    p0 = n_pop_a;
    b0 = brk_cnt_a;
    rxd_a = 1'b0;
    tick(12 * BIT);
    rxd_a = 1'b1;
    tick(2 * BIT);
    exp_brk_a++;
    check("break_pulses", brk_cnt_a - b0, 1);
    check("break_no_push", n_pop_a - p0, 0);

    // Random characters, errors and consumer back-pressure on both ports.
    rnd_rdy = 1'b1;
    for (int i = 0; i < 12; i++) begin
      d   = 8'($urandom);
      if ($urandom_range(0, 5) == 0) d = 8'h00;
      bad = ($urandom_range(0, 7) == 0);
      send(0, d, 0, bad ? 2'b10 : 2'b11, bad ? BIT + 4 + int'($urandom_range(0, 8))
                                             : int'($urandom_range(0, 6)), 1);
      d   = 8'($urandom);
      if ($urandom_range(0, 5) == 0) d = 8'h00;
      sv  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
      send(1, d, 1'($urandom_range(0, 1)), sv,
           (sv != 2'b11) ? BIT + 4 + int'($urandom_range(0, 8)) : int'($urandom_range(0, 6)), 1);
    end
    rnd_rdy = 1'b0;
    tick(2);
    rdy_a = 1'b1;
    rdy_b = 1'b1;
    tick(BIT);
    check("rnd_a_all_seen", qa.size(), 0);
    check("rnd_b_all_seen", qb.size(), 0);
    check("rnd_a_breaks", brk_cnt_a, exp_brk_a);
    check("rnd_b_breaks", brk_cnt_b, exp_brk_b);

    // Reset in the middle of a character with one entry held in the FIFO.
    rdy_a = 1'b0;
    send(0, 8'h11, 0, 2'b11, 4, 1);
    @(negedge clk);
    check("pre_reset_cnt", cnt_a, 1);
    @(posedge clk); #1;
    rxd_a = 1'b0;
    tick(BIT);
    rxd_a = 1'b1;
    tick(BIT);
    rxd_a = 1'b0;
    tick(BIT / 2);
    rst   = 1'b1;
    rxd_a = 1'b1;
    tick(1);
    rst = 1'b0;
    qa.delete();
    @(negedge clk);
    check("rst_vld_cnt", {vld_a, cnt_a}, 0);
    check("rst_flags", {ovf_a, brk_a, perr_a, ferr_a}, 0);
    check("rst_data", data_a, 0);
    tick(3 * BIT);
    @(negedge clk);
    check("rst_no_partial", {vld_a, cnt_a}, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got time limit, expected completion");
    $fatal(1, "simulation time limit");
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Parametrised next-generation UART receive path for the COM_IO subsystem.
- Generalises the fixed 8N1 receiver with compile-time data width, parity mode, stop-bit count, 3-sample majority voting, per-character error flags and an on-chip receive FIFO with overflow tracking.
- Sits between the UART_RXD pin and the UART control/command parser. The parser pops characters through a valid/ready handshake.

Parameters:
- C_BIT_CNT, 12'h364, clocks per bit (868 = 100 MHz / 115200); legal 16..4095.
- C_DATA_BITS, 8, data bits per character; legal 5..9.
- C_PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
- C_STOP_BITS, 1, stop bits checked; legal 1 or 2.
- C_FIFO_AW, 4, FIFO address width; depth = 2**C_FIFO_AW.

Ports:
- CLK_100M  in  1  system clock 100 MHz.
- IO_RESET  in  1  synchronous reset, active-high.
- UART_RXD  in  1  asynchronous serial input, idle high.
- RX_DATA  out  C_DATA_BITS  FIFO head character, LSB received first.
- RX_PERR  out  1  parity error flag of head entry.
- RX_FERR  out  1  framing error flag of head entry.
- RX_VLD  out  1  FIFO non-empty; head entry valid.
- RX_RDY  in  1  consumer pop; an entry is popped when RX_VLD && RX_RDY.
- RX_OVF  out  1  sticky overflow flag.
- OVF_CLR  in  1  clears RX_OVF.
- RX_BREAK  out  1  one-cycle pulse on break detect.
- FIFO_CNT  out  C_FIFO_AW+1  FIFO occupancy.

Behaviour:
- Reset (synchronous, IO_RESET=1 on a CLK_100M edge):
  - FSM returns to IDLE; FIFO pointers clear.
  - Outputs: RX_VLD=0, RX_OVF=0, RX_BREAK=0, FIFO_CNT=0, RX_DATA=0, RX_PERR=0, RX_FERR=0.
  - A character in flight is discarded. The synchronizer presets to 1.
- Input sync: 2-FF synchronizer, then 1 edge-detect register. The start falling edge is seen 3 cycles after the pin edge.
- Bit timer: counts 0..C_BIT_CNT-1 and restarts on each bit.
  - Samples are taken at counts H-1, H and H+1, where H = C_BIT_CNT/2 (floor).
  - Bit value = majority of the 3 samples.
- FSM states: IDLE, START, DATA, PARITY, STOP, PUSH, WAIT_IDLE.
  - IDLE: on synced falling edge, go to START with timer = 0.
  - START: at count H+1, a majority-1 result is a false start and returns to IDLE with no push. Otherwise stay until the bit end, then go to DATA.
  - DATA: shift C_DATA_BITS bits LSB-first. Go to PARITY if C_PARITY != 0, else STOP.
  - PARITY: perr = received bit != expected. Expected is XOR of data for even, ~XOR for odd.
  - STOP: check C_STOP_BITS bits; any majority-0 stop bit sets ferr. Decision is taken at the H+1 sample of the last stop bit; there is no wait for the bit end. Then go to PUSH.
  - PUSH: one cycle.
    - Break case (data all-zero, ferr=1, and the parity bit, if present, also 0): pulse RX_BREAK, do not push, go to WAIT_IDLE.
    - Otherwise write {perr, ferr, data}. Go to WAIT_IDLE if ferr, else IDLE.
  - WAIT_IDLE: leave only after the synced line has been 1 for a full C_BIT_CNT cycles.
- FIFO: first-word-fall-through.
  - RX_VLD and RX_DATA/flags update the cycle after the write.
  - Push when full: if a pop occurs in the same cycle, the push is accepted. Otherwise the character is dropped and RX_OVF is set.
  - Push and pop in the same cycle with non-empty FIFO: FIFO_CNT unchanged.
  - Pop when empty: ignored.
  - Pointers wrap modulo depth; occupancy is the extra-bit pointer difference.
- RX_OVF: OVF_CLR clears it. If OVF_CLR and a new overflow occur in the same cycle, set wins.
- RX_BREAK and RX_OVF are independent of the handshake.

Decomposition:
- Package uart_pkg: parity-mode constants (PAR_NONE/ODD/EVEN), FSM state encodings, function f_parity(data, mode).
- Sub-module uart_sync_fifo: parameter width and address width; ports push/pop/full/empty/count. Reused later by a TX path.
- Top instantiates the synchronizer, timer, FSM and uart_sync_fifo.

Test Plan:
- 8N1 at C_BIT_CNT=868, send 0x55 then 0xA3 back-to-back, RX_RDY=1 -> RX_VLD pulses twice, RX_DATA 0x55 then 0xA3, PERR=FERR=0, FIFO_CNT never exceeds 1.
- C_PARITY=2, C_DATA_BITS=7, send 0x41 with correct then inverted parity -> entry 1 PERR=0, entry 2 PERR=1, both RX_DATA=0x41.
- Glitch: RXD low 300 cycles (< H) -> no push, FSM back in IDLE; a following valid 0x3C is received correctly.
- Stop bit forced 0 on 0x7E -> entry RX_FERR=1; the next start edge is ignored until the line has been high for 868 cycles.
- RX_RDY=0, send 17 characters at depth 16 -> FIFO_CNT=16, RX_OVF=1, 17th character lost. OVF_CLR pulse -> RX_OVF=0. Drain yields the first 16 in order.
- Break: RXD low for 12 bit times -> single RX_BREAK pulse, no FIFO write. Apply IO_RESET mid-character -> all outputs at reset values, no partial entry.
